// File: rtl/lbdr_input_buffer_if.sv
// Link-side and LBDR-side signals of one router input buffer.
// The master drives flits in and pops; the slave (the buffer) presents the head flit and its flags.
interface lbdr_input_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 2
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] flit_out;
  logic [2:0]            flit_id;
  logic [3:0]            dst_addr;
  logic                  empty;
  logic                  full;
  logic [PTR_WIDTH:0]    count;
  logic                  credit_out;
  logic                  overflow;
  logic                  frame_err;

  modport master (
    output valid_in, flit_in, read_en,
    input  flit_out, flit_id, dst_addr, empty, full, count, credit_out, overflow, frame_err
  );

  modport slave (
    input  valid_in, flit_in, read_en,
    output flit_out, flit_id, dst_addr, empty, full, count, credit_out, overflow, frame_err
  );
endinterface

// File: rtl/lbdr_input_buffer.sv
// First-word-fall-through input FIFO feeding LBDR: credit return on every pop, sticky
// overflow flag and a write-side packet framing checker.
module lbdr_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input logic                clk,
  input logic                rst,
  lbdr_input_buffer_if.slave bus
);

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  typedef enum logic {IDLE, IN_PKT} frame_state_e;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic [3:0]            dst_reg_q, dst_reg_d;
  logic                  credit_q, overflow_q, frame_err_q;
  frame_state_e          state_q;

  logic [DATA_WIDTH-1:0] head_flit;
  logic [2:0]            head_id, in_id;
  logic                  is_empty, is_full, wr_acc, rd_acc;

  assign head_flit = mem_q[rd_ptr_q];
  assign head_id   = head_flit[DATA_WIDTH-1 -: 3];
  assign in_id     = bus.flit_in[DATA_WIDTH-1 -: 3];
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == (PTR_WIDTH+1)'(FIFO_DEPTH));
  // A write into a full buffer is dropped even if a pop frees a slot this cycle.
  assign wr_acc    = bus.valid_in && !is_full;
  assign rd_acc    = bus.read_en && !is_empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dst_reg_d = dst_reg_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Remember the packet's destination once its header leaves, for the body flits.
    if (rd_acc && head_id == HEADER) dst_reg_d = head_flit[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dst_reg_q  <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dst_reg_q <= dst_reg_d;
      credit_q  <= rd_acc;
      if (bus.valid_in && is_full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.flit_in;
  end

  // Framing only observes accepted writes; bad flits are still stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_err_q <= 1'b0;
    end else if (wr_acc) begin
      case (state_q)
        IDLE: begin
          if (in_id == HEADER) state_q <= IN_PKT;
          else                 frame_err_q <= 1'b1;
        end
        IN_PKT: begin
          case (in_id)
            PAYLOAD: state_q <= IN_PKT;
            TAIL:    state_q <= IDLE;
            default: frame_err_q <= 1'b1;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.flit_out   = head_flit;
  assign bus.flit_id    = head_id;
  assign bus.dst_addr   = (head_id == HEADER) ? head_flit[3:0] : dst_reg_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.count      = count_q;
  assign bus.credit_out = credit_q;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_lbdr_input_buffer.sv
// Directed bench for lbdr_input_buffer: a vector table for the per-cycle behaviour,
// then hand-written streaming/wrap and asynchronous mid-operation reset sequences.
module tb_lbdr_input_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lbdr_input_buffer_if #(.DATA_WIDTH(32), .PTR_WIDTH(2)) bus ();

  lbdr_input_buffer #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PTR_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] f;
    logic        rd;
    int          cnt;
    logic        cr;
    logic        ov;
    logic        fe;
    logic        chk_head;
    logic [31:0] head;
    logic [3:0]  dst;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] f, input logic rd, input int cnt,
                     input logic cr, input logic ov, input logic fe, input logic chk_head,
                     input logic [31:0] head, input logic [3:0] dst);
    vec_t r;
    r.v = v; r.f = f; r.rd = rd; r.cnt = cnt; r.cr = cr; r.ov = ov; r.fe = fe;
    r.chk_head = chk_head; r.head = head; r.dst = dst;
    vecs.push_back(r);
  endtask

  initial begin
    // Expected values describe the state just after the clock edge that applies the row.
    //  v  flit          rd cnt cr ov fe chk head          dst
    add(1, 32'h2000_001A, 0, 1, 0, 0, 0, 1, 32'h2000_001A, 4'hA); // single header
    add(0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0,         4'h0);
    add(1, 32'h8000_00EE, 1, 1, 0, 0, 0, 1, 32'h8000_00EE, 4'hA); // write+read while empty
    add(0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0,         4'h0);
    add(0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         4'h0);
    add(1, 32'h2000_0036, 0, 1, 0, 0, 0, 1, 32'h2000_0036, 4'h6); // packet through
    add(1, 32'h4000_0011, 0, 2, 0, 0, 0, 1, 32'h2000_0036, 4'h6);
    add(1, 32'h4000_0022, 0, 3, 0, 0, 0, 1, 32'h2000_0036, 4'h6);
    add(1, 32'h8000_0033, 0, 4, 0, 0, 0, 1, 32'h2000_0036, 4'h6);
    add(0, 32'h0,         1, 3, 1, 0, 0, 1, 32'h4000_0011, 4'h6);
    add(0, 32'h0,         1, 2, 1, 0, 0, 1, 32'h4000_0022, 4'h6);
    add(0, 32'h0,         1, 1, 1, 0, 0, 1, 32'h8000_0033, 4'h6);
    add(0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0,         4'h0);
    add(0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         4'h0);
    add(1, 32'h2000_0045, 0, 1, 0, 0, 0, 1, 32'h2000_0045, 4'h5); // fill, wraps the pointers
    add(1, 32'h4000_0055, 0, 2, 0, 0, 0, 1, 32'h2000_0045, 4'h5);
    add(1, 32'h4000_0066, 0, 3, 0, 0, 0, 1, 32'h2000_0045, 4'h5);
    add(1, 32'h8000_0077, 0, 4, 0, 0, 0, 1, 32'h2000_0045, 4'h5);
    add(1, 32'h4000_0099, 1, 3, 1, 1, 0, 1, 32'h4000_0055, 4'h5); // overflow drop with pop
    add(0, 32'h0,         0, 3, 0, 1, 0, 1, 32'h4000_0055, 4'h5);
    add(0, 32'h0,         1, 2, 1, 1, 0, 1, 32'h4000_0066, 4'h5);
    add(0, 32'h0,         1, 1, 1, 1, 0, 1, 32'h8000_0077, 4'h5);
    add(0, 32'h0,         1, 0, 1, 1, 0, 0, 32'h0,         4'h0);
    add(0, 32'h0,         0, 0, 0, 1, 0, 0, 32'h0,         4'h0);
    add(1, 32'h4000_00AB, 0, 1, 0, 1, 1, 1, 32'h4000_00AB, 4'h5); // payload in IDLE
    add(0, 32'h0,         1, 0, 1, 1, 1, 0, 32'h0,         4'h0);
    add(1, 32'h2000_0027, 0, 1, 0, 1, 1, 1, 32'h2000_0027, 4'h7); // legal packet, err sticky
    add(1, 32'h8000_0001, 0, 2, 0, 1, 1, 1, 32'h2000_0027, 4'h7);
    add(0, 32'h0,         1, 1, 1, 1, 1, 1, 32'h8000_0001, 4'h7);
    add(0, 32'h0,         1, 0, 1, 1, 1, 0, 32'h0,         4'h0);
    add(1, 32'h2000_003C, 1, 1, 0, 1, 1, 1, 32'h2000_003C, 4'hC);
    add(0, 32'h0,         1, 0, 1, 1, 1, 0, 32'h0,         4'h0);

    bus.valid_in = 1'b0;
    bus.flit_in  = '0;
    bus.read_en  = 1'b0;

    #3;
    chk("rst_empty",    32'(bus.empty),      32'd1);
    chk("rst_full",     32'(bus.full),       32'd0);
    chk("rst_count",    32'(bus.count),      32'd0);
    chk("rst_credit",   32'(bus.credit_out), 32'd0);
    chk("rst_overflow", 32'(bus.overflow),   32'd0);
    chk("rst_frame",    32'(bus.frame_err),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.valid_in = vecs[i].v;
      bus.flit_in  = vecs[i].f;
      bus.read_en  = vecs[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i),    32'(bus.count),      32'(vecs[i].cnt));
      chk($sformatf("v%0d_empty", i),    32'(bus.empty),      32'(vecs[i].cnt == 0));
      chk($sformatf("v%0d_full", i),     32'(bus.full),       32'(vecs[i].cnt == 4));
      chk($sformatf("v%0d_credit", i),   32'(bus.credit_out), 32'(vecs[i].cr));
      chk($sformatf("v%0d_overflow", i), 32'(bus.overflow),   32'(vecs[i].ov));
      chk($sformatf("v%0d_frame", i),    32'(bus.frame_err),  32'(vecs[i].fe));
      if (vecs[i].chk_head) begin
        chk($sformatf("v%0d_flit", i), bus.flit_out,        vecs[i].head);
        chk($sformatf("v%0d_id", i),   32'(bus.flit_id),    32'(vecs[i].head[31:29]));
        chk($sformatf("v%0d_dst", i),  32'(bus.dst_addr),   32'(vecs[i].dst));
      end
    end

    // Continuous stream of 10 flits with a pop every cycle: order kept, occupancy stays at 1.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.valid_in = (i < 10);
      bus.flit_in  = (i == 9) ? (32'h8000_0100 + 32'(i)) : (32'h4000_0100 + 32'(i));
      bus.read_en  = (i > 0);
      if (bus.read_en && model.size() > 0) void'(model.pop_front());
      if (bus.valid_in) model.push_back(bus.flit_in);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d_count", i),  32'(bus.count),      32'(model.size()));
      chk($sformatf("wrap%0d_credit", i), 32'(bus.credit_out), 32'(i > 0));
      if (model.size() > 0) chk($sformatf("wrap%0d_order", i), bus.flit_out, model[0]);
    end

    // Asynchronous reset with three flits stored and a credit pending.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.valid_in = (i < 4);
      bus.flit_in  = (i == 0) ? 32'h2000_0042 : 32'h4000_0200 + 32'(i);
      bus.read_en  = (i == 4);
      @(posedge clk);
      #1;
    end
    chk("pre_rst_count",  32'(bus.count),      32'd3);
    chk("pre_rst_credit", 32'(bus.credit_out), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_empty",    32'(bus.empty),      32'd1);
    chk("mid_rst_count",    32'(bus.count),      32'd0);
    chk("mid_rst_full",     32'(bus.full),       32'd0);
    chk("mid_rst_credit",   32'(bus.credit_out), 32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow),   32'd0);
    chk("mid_rst_frame",    32'(bus.frame_err),  32'd0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.read_en  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_credit", i), 32'(bus.credit_out), 32'd0);
      chk($sformatf("post_rst%0d_empty", i),  32'(bus.empty),      32'd1);
    end
    bus.read_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
